// File: rtl/wb_cmd_master_if.sv
// Bus bundle for wb_cmd_master: the controller command/response stream
// and the pipelined Wishbone master port. Port names keep their i_/o_
// prefixes as seen from the master. The master modport is used by the
// design. The slave modport is the view of whoever drives the command
// stream and plays the Wishbone slave.
interface wb_cmd_master_if #(
  parameter int AW = 30
) ();

  // Command stream from the core controller.
  logic          i_cmd_stb;
  logic [33:0]   i_cmd_word;
  logic          o_cmd_busy;

  // Response stream back to the core controller.
  logic          o_rsp_stb;
  logic [33:0]   o_rsp_word;

  // Wishbone pipelined master signals.
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_stall;
  logic          i_wb_ack;
  logic          i_wb_err;
  logic [31:0]   i_wb_data;

  modport master (
    input  i_cmd_stb,
    input  i_cmd_word,
    output o_cmd_busy,
    output o_rsp_stb,
    output o_rsp_word,
    output o_wb_cyc,
    output o_wb_stb,
    output o_wb_we,
    output o_wb_addr,
    output o_wb_data,
    output o_wb_sel,
    input  i_wb_stall,
    input  i_wb_ack,
    input  i_wb_err,
    input  i_wb_data
  );

  modport slave (
    output i_cmd_stb,
    output i_cmd_word,
    input  o_cmd_busy,
    input  o_rsp_stb,
    input  o_rsp_word,
    input  o_wb_cyc,
    input  o_wb_stb,
    input  o_wb_we,
    input  o_wb_addr,
    input  o_wb_data,
    input  o_wb_sel,
    output i_wb_stall,
    output i_wb_ack,
    output i_wb_err,
    output i_wb_data
  );

endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: pipelined Wishbone bus master for the multi-cycle RISC-V
// core. It takes one 34-bit command at a time and returns one 34-bit
// response for each command it accepts.
//
// Command op [33:32]:
//   00 read
//   01 write
//   10 set address
//   11 set address with auto-increment
//
// Response code [33:32]:
//   00 read data
//   01 write ack
//   10 address ack
//   11 bus error
//
// Optional feature: define WB_MASTER_TIMEOUT_EN to add a watchdog. The
// watchdog aborts a bus cycle that gets neither ack nor err within
// TIMEOUT_CYCLES cycles. When the macro is undefined, the master waits
// indefinitely.
//
// The address payload is {addr,2'b00} zero-extended to 32 bits, so AW
// must not exceed 30.
module wb_cmd_master #(
  parameter int AW             = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            reset,
  wb_cmd_master_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [1:0] RSP_READ  = 2'b00;
  localparam logic [1:0] RSP_WRITE = 2'b01;
  localparam logic [1:0] RSP_ADDR  = 2'b10;
  localparam logic [1:0] RSP_ERR   = 2'b11;

  logic [1:0]    state;
  logic [AW-1:0] addr;
  logic          inc;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [31:0]   wdata;
  logic          rsp_stb;
  logic [33:0]   rsp_word;

  logic [1:0]    op;
  logic [AW-1:0] cmd_addr;
  logic          resolve;
  logic          expire;

  // Expands a word address into the 32-bit byte address carried in a
  // response payload.
  function automatic logic [31:0] byte_addr(input logic [AW-1:0] a);
    logic [31:0] r;
    r = '0;
    r[AW+1:0] = {a, 2'b00};
    return r;
  endfunction

  assign op       = bus.i_cmd_word[33:32];
  assign cmd_addr = bus.i_cmd_word[AW+1:2];

  // ack/err only count once the strobe has left the master. In REQ with
  // no stall, the strobe is accepted on this edge, so a same-cycle ack
  // is honoured as if we were already in WAIT.
  assign resolve = (state == WAIT) || ((state == REQ) && !bus.i_wb_stall);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW > 8) ? TW_RAW : 8;

  logic [TW-1:0] timer;

  assign expire = cyc && (timer == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles with cyc high, restarts on every accepted command.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (bus.i_cmd_stb && (state == IDLE)) begin
      timer <= '0;
    end else if (cyc) begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // Command FSM: accepts commands, runs the Wishbone transfer and
  // produces the one-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      inc      <= 1'b0;
      cyc      <= 1'b0;
      stb      <= 1'b0;
      we       <= 1'b0;
      wdata    <= '0;
      rsp_stb  <= 1'b0;
      rsp_word <= '0;
    end else begin
      rsp_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_cmd_stb) begin
            if (op[1]) begin
              addr     <= cmd_addr;
              inc      <= op[0];
              rsp_stb  <= 1'b1;
              rsp_word <= {RSP_ADDR, byte_addr(cmd_addr)};
            end else begin
              state <= REQ;
              cyc   <= 1'b1;
              stb   <= 1'b1;
              we    <= op[0];
              wdata <= bus.i_cmd_word[31:0];
            end
          end
        end
        REQ, WAIT: begin
          if ((state == REQ) && !bus.i_wb_stall) begin
            stb   <= 1'b0;
            state <= WAIT;
          end
          if (resolve && bus.i_wb_err) begin
            cyc      <= 1'b0;
            stb      <= 1'b0;
            state    <= IDLE;
            rsp_stb  <= 1'b1;
            rsp_word <= {RSP_ERR, byte_addr(addr)};
          end else if (resolve && bus.i_wb_ack) begin
            cyc     <= 1'b0;
            stb     <= 1'b0;
            state   <= IDLE;
            rsp_stb <= 1'b1;
            if (we) begin
              rsp_word <= {RSP_WRITE, 32'h0};
            end else begin
              rsp_word <= {RSP_READ, bus.i_wb_data};
            end
            if (inc) begin
              addr <= addr + 1'b1;
            end
          end else if (expire) begin
            cyc      <= 1'b0;
            stb      <= 1'b0;
            state    <= IDLE;
            rsp_stb  <= 1'b1;
            rsp_word <= {RSP_ERR, byte_addr(addr)};
          end
        end
        default: begin
          state <= IDLE;
          cyc   <= 1'b0;
          stb   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_cmd_busy = (state != IDLE);
  assign bus.o_rsp_stb  = rsp_stb;
  assign bus.o_rsp_word = rsp_word;
  assign bus.o_wb_cyc   = cyc;
  assign bus.o_wb_stb   = stb;
  assign bus.o_wb_we    = we;
  assign bus.o_wb_addr  = addr;
  assign bus.o_wb_data  = wdata;
  assign bus.o_wb_sel   = 4'hF;

endmodule
